// File: rtl/l2_request_arbiter.sv
// -----------------------------------------------------------------------------
// l2_request_arbiter
//
// Round-robin arbiter that shares the single L2 cache request port among
// NUM_CORES cores. A one-entry registered output stage holds the winning
// request until l2_cache accepts it. It can be refilled in the same cycle it
// drains, which sustains one request per cycle. Each forwarded request is
// tagged with its source core index. A performance event pulses whenever
// more than one core competes on a cycle in which the stage is loaded.
//
// Ports
//   clk                    core clock
//   reset                  asynchronous, active-high
//   req_valid   [N]        core i has a request pending
//   req_packet  [N*PW]     core i packet at [i*PACKET_WIDTH +: PACKET_WIDTH]
//   req_ready   [N]        core i request accepted this cycle (one-hot or 0)
//   l2req_valid            output stage holds a request
//   l2req_packet [PW]      packet presented to l2_cache
//   l2req_core  [CIW]      source core index of l2req_packet
//   l2req_ready            l2_cache accepts l2req_packet this cycle
//   pc_event_arb_conflict  registered pulse: >1 core valid on a load cycle
// -----------------------------------------------------------------------------
module l2_request_arbiter #(
    parameter int NUM_CORES     = 2,
    parameter int PACKET_WIDTH  = 128,
    parameter int CORE_ID_WIDTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CORES-1:0]              req_valid,
    input  logic [NUM_CORES*PACKET_WIDTH-1:0] req_packet,
    output logic [NUM_CORES-1:0]              req_ready,
    output logic                              l2req_valid,
    output logic [PACKET_WIDTH-1:0]           l2req_packet,
    output logic [CORE_ID_WIDTH-1:0]          l2req_core,
    input  logic                              l2req_ready,
    output logic                              pc_event_arb_conflict
);

    localparam logic [CORE_ID_WIDTH-1:0] LAST_CORE = CORE_ID_WIDTH'(NUM_CORES - 1);

    logic                     l2req_valid_q,  l2req_valid_d;
    logic [PACKET_WIDTH-1:0]  l2req_packet_q, l2req_packet_d;
    logic [CORE_ID_WIDTH-1:0] l2req_core_q,   l2req_core_d;
    logic [CORE_ID_WIDTH-1:0] last_grant_q,   last_grant_d;
    logic                     pc_event_q,     pc_event_d;

    logic                     load;
    logic                     any_valid;
    logic                     multi_valid;
    logic [NUM_CORES-1:0]     upper_mask;
    logic [NUM_CORES-1:0]     upper_req;
    logic [NUM_CORES-1:0]     grant;
    logic [CORE_ID_WIDTH-1:0] sel_idx;
    logic [PACKET_WIDTH-1:0]  sel_packet;

    // The stage accepts a new entry when empty or when its current entry
    // leaves this cycle.
    assign load      = !l2req_valid_q || l2req_ready;
    assign any_valid = |req_valid;

    // Clearing the lowest set bit leaves something iff two or more are set.
    assign multi_valid = |(req_valid & (req_valid - NUM_CORES'(1)));

    // Round-robin selection as a two-level priority search: first look at
    // cores strictly above the last grant, and if none is requesting, wrap
    // around to the lowest-numbered requester overall.
    always_comb begin
        upper_mask = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            upper_mask[i] = (i > int'(last_grant_q));
        end
        upper_req = req_valid & upper_mask;

        grant   = '0;
        sel_idx = '0;
        if (|upper_req) begin
            for (int i = NUM_CORES - 1; i >= 0; i--) begin
                if (upper_req[i]) begin
                    grant   = '0;
                    grant[i] = 1'b1;
                    sel_idx = CORE_ID_WIDTH'(i);
                end
            end
        end else begin
            for (int i = NUM_CORES - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    grant   = '0;
                    grant[i] = 1'b1;
                    sel_idx = CORE_ID_WIDTH'(i);
                end
            end
        end
    end

    // One-hot AND-OR mux keeps the packet path free of a variable index.
    always_comb begin
        sel_packet = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) begin
                sel_packet = sel_packet | req_packet[i*PACKET_WIDTH +: PACKET_WIDTH];
            end
        end
    end

    // With a single core the ready signal is just the load condition, so
    // the block behaves as a plain pipeline register.
    generate
        if (NUM_CORES == 1) begin : g_single
            assign req_ready = load;
        end else begin : g_multi
            assign req_ready = load ? grant : '0;
        end
    endgenerate

    always_comb begin
        l2req_valid_d  = l2req_valid_q;
        l2req_packet_d = l2req_packet_q;
        l2req_core_d   = l2req_core_q;
        last_grant_d   = last_grant_q;
        pc_event_d     = load && multi_valid;

        if (load) begin
            if (any_valid) begin
                l2req_valid_d  = 1'b1;
                l2req_packet_d = sel_packet;
                l2req_core_d   = sel_idx;
                last_grant_d   = sel_idx;
            end else begin
                // Empty load: drop valid but keep the packet, the tag and the
                // rotation pointer so fairness survives idle gaps.
                l2req_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l2req_valid_q  <= 1'b0;
            l2req_packet_q <= '0;
            l2req_core_q   <= '0;
            last_grant_q   <= LAST_CORE;
            pc_event_q     <= 1'b0;
        end else begin
            l2req_valid_q  <= l2req_valid_d;
            l2req_packet_q <= l2req_packet_d;
            l2req_core_q   <= l2req_core_d;
            last_grant_q   <= last_grant_d;
            pc_event_q     <= pc_event_d;
        end
    end

    assign l2req_valid           = l2req_valid_q;
    assign l2req_packet          = l2req_packet_q;
    assign l2req_core            = l2req_core_q;
    assign pc_event_arb_conflict = pc_event_q;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// -----------------------------------------------------------------------------
// tb_l2_request_arbiter
//
// Directed bench for l2_request_arbiter with four cores. Each core presents a
// fixed, distinct packet so that l2req_packet identifies the winner. Inputs
// are driven 1 time unit after the rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_l2_request_arbiter;

    localparam int NC  = 4;
    localparam int PW  = 32;
    localparam int CIW = 4;

    logic                 clk;
    logic                 reset;
    logic [NC-1:0]        req_valid;
    logic [NC*PW-1:0]     req_packet;
    logic [NC-1:0]        req_ready;
    logic                 l2req_valid;
    logic [PW-1:0]        l2req_packet;
    logic [CIW-1:0]       l2req_core;
    logic                 l2req_ready;
    logic                 pc_event_arb_conflict;

    int tests_run;
    int tests_failed;
    int exp_core;

    l2_request_arbiter #(
        .NUM_CORES    (NC),
        .PACKET_WIDTH (PW),
        .CORE_ID_WIDTH(CIW)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .req_valid            (req_valid),
        .req_packet           (req_packet),
        .req_ready            (req_ready),
        .l2req_valid          (l2req_valid),
        .l2req_packet         (l2req_packet),
        .l2req_core           (l2req_core),
        .l2req_ready          (l2req_ready),
        .pc_event_arb_conflict(pc_event_arb_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pkt(input int i);
        return 32'hC0DE_0000 + PW'(i) * 32'h0000_1111;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < NC; i++) req_packet[i*PW +: PW] = pkt(i);

        // Reset with two requesters pending
        reset       = 1'b1;
        req_valid   = 4'b0011;
        l2req_ready = 1'b0;
        step();
        step();
        check("rst_valid",   64'(l2req_valid), 64'd0);
        check("rst_packet",  64'(l2req_packet), 64'd0);
        check("rst_core",    64'(l2req_core), 64'd0);
        check("rst_pc",      64'(pc_event_arb_conflict), 64'd0);

        reset = 1'b0;
        #1;
        check("first_ready", 64'(req_ready), 64'h1);
        step();
        check("first_valid", 64'(l2req_valid), 64'd1);
        check("first_core",  64'(l2req_core), 64'd0);
        check("first_pkt",   64'(l2req_packet), 64'(pkt(0)));
        check("first_pc",    64'(pc_event_arb_conflict), 64'd1);
        check("stall_ready0", 64'(req_ready), 64'h0);

        // Backpressure: five stalled cycles, entry must stay put
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_core",  64'(l2req_core), 64'd0);
            check("bp_pkt",   64'(l2req_packet), 64'(pkt(0)));
            check("bp_ready", 64'(req_ready), 64'h0);
            check("bp_pc",    64'(pc_event_arb_conflict), 64'd0);
        end
        // Drain and refill in the same cycle: core 1 is next after core 0
        l2req_ready = 1'b1;
        #1;
        check("refill_ready", 64'(req_ready), 64'h2);
        step();
        check("refill_valid", 64'(l2req_valid), 64'd1);
        check("refill_core",  64'(l2req_core), 64'd1);
        check("refill_pkt",   64'(l2req_packet), 64'(pkt(1)));

        // All four continuously valid: rotation 2,3,0,1,2,3,0,1,2,3
        req_valid = 4'hF;
        exp_core  = 1;
        for (int c = 0; c < 10; c++) begin
            exp_core = (exp_core + 1) % NC;
            #1;
            check("rr_ready", 64'(req_ready), 64'(1 << exp_core));
            step();
            check("rr_core",  64'(l2req_core), 64'(exp_core));
            check("rr_pkt",   64'(l2req_packet), 64'(pkt(exp_core)));
            check("rr_pc",    64'(pc_event_arb_conflict), 64'd1);
        end

        // Only core 2 after a core 3 grant: wrap search lands on 2
        req_valid = 4'b0100;
        #1;
        check("wrap_ready", 64'(req_ready), 64'h4);
        step();
        check("wrap_core",  64'(l2req_core), 64'd2);
        check("wrap_pc",    64'(pc_event_arb_conflict), 64'd0);

        // Idle: valid drops, tag held
        req_valid = 4'b0000;
        #1;
        check("idle_ready", 64'(req_ready), 64'h0);
        step();
        check("idle_valid", 64'(l2req_valid), 64'd0);
        check("idle_core",  64'(l2req_core), 64'd2);
        step();
        check("idle_valid2", 64'(l2req_valid), 64'd0);

        // Pointer still at 2: among cores 1 and 3, core 3 wins
        req_valid = 4'b1010;
        #1;
        check("hold_ready", 64'(req_ready), 64'h8);
        step();
        check("hold_core",  64'(l2req_core), 64'd3);
        check("hold_pc",    64'(pc_event_arb_conflict), 64'd1);
        req_valid = 4'b0010;
        #1;
        check("c1_ready", 64'(req_ready), 64'h2);
        step();
        check("c1_core",  64'(l2req_core), 64'd1);
        check("c1_valid", 64'(l2req_valid), 64'd1);

        // Async reset while an entry is stalled
        req_valid   = 4'b0011;
        l2req_ready = 1'b0;
        step();
        check("pre_rst_valid", 64'(l2req_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid",  64'(l2req_valid), 64'd0);
        check("arst_packet", 64'(l2req_packet), 64'd0);
        check("arst_core",   64'(l2req_core), 64'd0);
        step();
        reset = 1'b0;
        #1;
        check("post_rst_ready", 64'(req_ready), 64'h1);
        step();
        check("post_rst_core",  64'(l2req_core), 64'd0);
        check("post_rst_valid", 64'(l2req_valid), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
